// File: rtl/uart_rx_port_if.sv
// CPU-side bus strobes and address for the memory-mapped UART receiver.
// The tri-state read data stays a plain port on the receiver.
interface uart_rx_port_if;
    logic        ce;
    logic        r;
    logic        oe;
    logic [15:0] addr;

    modport master (output ce, r, oe, addr);
    modport slave  (input  ce, r, oe, addr);
endinterface

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: one-byte holding register plus status
// flags, read back over the shared bus at BASE_ADDR (data) and BASE_ADDR+1.
module uart_rx_port #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          CLKS_PER_BIT = 234
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_port_if.slave bus,
    input  logic          rx,
    output wire  [7:0]    out_data,
    output logic          rx_ready
);
    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [7:0]       rd_q, rd_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic             hit, sel, rd_en, pop, stat_rd;
    logic             stop_good, stop_bad, load;

    assign rx_s     = sync_q[1];
    assign hit      = (bus.addr == BASE_ADDR) || (bus.addr == BASE_ADDR + 16'd1);
    assign sel      = (bus.addr == BASE_ADDR + 16'd1);
    assign rd_en    = bus.ce & bus.r & hit;
    assign pop      = rd_en & ~sel;
    assign stat_rd  = rd_en & sel;
    assign out_data = (bus.ce & bus.oe & hit) ? rd_q : 8'bz;
    assign rx_ready = valid_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == MID) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        stop_good = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                // a line held low must go high before another start is armed
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop on the same edge frees the holding register, so the new byte lands
    // without being counted as an overrun; flag sets win over status clears.
    always_comb begin
        load      = stop_good & (~valid_q | pop);
        rx_data_d = load ? shift_q : rx_data_q;
        valid_d   = load | (valid_q & ~pop);
        ovr_d     = (ovr_q & ~stat_rd) | (stop_good & valid_q & ~pop);
        ferr_d    = (ferr_q & ~stat_rd) | stop_bad;
        rd_d      = rd_q;
        if (rd_en) rd_d = sel ? {5'b0, ferr_q, ovr_q, valid_q} : rx_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            sync_q    <= 2'b11;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            sync_q    <= {sync_q[0], rx};
        end
    end
endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: a vector table of frame/read operations, hand-timed
// corner sequences, and random traffic against a frame-level model.
module tb_uart_rx_port;
    localparam int          CPB  = 8;
    localparam logic [15:0] BASE = 16'hFF00;
    localparam logic [15:0] STAT = 16'hFF01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic rx_ready;
    tri1 [7:0] out_data;

    uart_rx_port_if bus ();

    uart_rx_port #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rx       (rx),
        .out_data (out_data),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef enum {OP_READ, OP_SEND, OP_RDY} op_t;
    typedef struct {
        op_t         op;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        stop;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl[$];

    // frame-level reference state
    logic [7:0] m_data;
    logic       m_valid, m_ovr, m_ferr;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        bus.ce = 1'b1; bus.r = 1'b1; bus.oe = 1'b1; bus.addr = a;
        tick(1);
        d = out_data;
        bus.ce = 1'b0; bus.r = 1'b0; bus.oe = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int hold);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        if (!stop) tick(hold);
        rx = 1'b1;
        tick(stop ? 1 : 4);
    endtask

    task automatic bus_peek(input logic ce, input logic oe, input logic [15:0] a,
                            output logic [7:0] d);
        bus.ce = ce; bus.r = 1'b0; bus.oe = oe; bus.addr = a;
        #2;
        d = out_data;
        bus.ce = 1'b0; bus.oe = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        bus.ce = 1'b0; bus.r = 1'b0; bus.oe = 1'b0; bus.addr = 16'h0000;

        // ---- reset and bus tri-state ----
        do_reset();
        chk("reset rx_ready", {7'b0, rx_ready}, 8'h00);
        bus_peek(1'b1, 1'b0, BASE, d);
        chk("hiz oe=0", d, 8'hFF);
        bus_peek(1'b1, 1'b1, 16'h1234, d);
        chk("hiz miss addr", d, 8'hFF);
        bus_peek(1'b0, 1'b1, STAT, d);
        chk("hiz ce=0", d, 8'hFF);
        bus_peek(1'b1, 1'b1, STAT, d);
        chk("driven after reset", d, 8'h00);

        // ---- table-driven frames and reads ----
        tbl.push_back('{OP_READ, STAT, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{OP_RDY,  16'h0, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{OP_SEND, 16'h0, 8'hA5, 1'b1, 8'h00});
        tbl.push_back('{OP_RDY,  16'h0, 8'h00, 1'b1, 8'h01});
        tbl.push_back('{OP_READ, STAT, 8'h00, 1'b1, 8'h01});
        tbl.push_back('{OP_READ, BASE, 8'h00, 1'b1, 8'hA5});
        tbl.push_back('{OP_READ, STAT, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{OP_SEND, 16'h0, 8'h3C, 1'b1, 8'h00});
        tbl.push_back('{OP_SEND, 16'h0, 8'hC3, 1'b1, 8'h00});
        tbl.push_back('{OP_READ, STAT, 8'h00, 1'b1, 8'h03});
        tbl.push_back('{OP_READ, BASE, 8'h00, 1'b1, 8'h3C});
        tbl.push_back('{OP_READ, STAT, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{OP_SEND, 16'h0, 8'h55, 1'b0, 8'h00});
        tbl.push_back('{OP_READ, STAT, 8'h00, 1'b1, 8'h04});
        tbl.push_back('{OP_READ, STAT, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{OP_READ, BASE, 8'h00, 1'b1, 8'h3C});
        tbl.push_back('{OP_RDY,  16'h0, 8'h00, 1'b1, 8'h00});
        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_SEND: send_frame(tbl[i].data, tbl[i].stop, 30);
                OP_READ: begin
                    bus_read(tbl[i].addr, d);
                    chk($sformatf("tbl[%0d] read %04h", i, tbl[i].addr), d, tbl[i].exp);
                end
                default: chk($sformatf("tbl[%0d] rx_ready", i), {7'b0, rx_ready}, tbl[i].exp);
            endcase
            tick(1);
        end

        // ---- glitch rejected, receiver still usable ----
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(20);
        bus_read(STAT, d);
        chk("glitch status", d, 8'h00);
        send_frame(8'h96, 1'b1, 0);
        bus_read(BASE, d);
        chk("after glitch data", d, 8'h96);

        // ---- rx_ready latency, then pop/load collision ----
        do_reset();
        fork
            send_frame(8'h11, 1'b1, 0);
            begin
                tick(76);
                chk("rdy early", {7'b0, rx_ready}, 8'h00);
                tick(4);
                chk("rdy late", {7'b0, rx_ready}, 8'h01);
            end
        join
        fork
            send_frame(8'h22, 1'b1, 0);
            begin
                tick(78);
                bus_read(BASE, d);
                chk("collision old byte", d, 8'h11);
            end
        join
        bus_read(STAT, d);
        chk("collision status", d, 8'h01);
        bus_read(BASE, d);
        chk("collision new byte", d, 8'h22);

        // ---- reset in the middle of a frame ----
        fork
            send_frame(8'hFF, 1'b1, 0);
            begin
                tick(43);
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
        join
        tick(4);
        bus_read(STAT, d);
        chk("midreset status", d, 8'h00);
        send_frame(8'h0F, 1'b1, 0);
        bus_read(STAT, d);
        chk("post-reset status", d, 8'h01);
        bus_read(BASE, d);
        chk("post-reset data", d, 8'h0F);

        // ---- random traffic against the frame-level model ----
        do_reset();
        m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        for (int k = 0; k < 40; k++) begin
            int sel;
            logic [7:0] b;
            sel = $urandom_range(0, 9);
            b   = 8'($urandom);
            if (sel <= 3) begin
                send_frame(b, 1'b1, 0);
                if (!m_valid) begin
                    m_data  = b;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (sel == 4) begin
                send_frame(b, 1'b0, $urandom_range(0, 20));
                m_ferr = 1'b1;
            end else if (sel <= 7) begin
                bus_read(BASE, d);
                chk($sformatf("rand[%0d] data", k), d, m_data);
                m_valid = 1'b0;
            end else begin
                bus_read(STAT, d);
                chk($sformatf("rand[%0d] status", k), d, {5'b0, m_ferr, m_ovr, m_valid});
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end
            chk($sformatf("rand[%0d] rx_ready", k), {7'b0, rx_ready}, {7'b0, m_valid});
            tick($urandom_range(0, 3));
        end
        bus_read(STAT, d);
        chk("rand final status", d, {5'b0, m_ferr, m_ovr, m_valid});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
